// File: rtl/sram_req_bridge_pkg.sv
// Shared types for sram_req_bridge: FSM states, command-stage payload,
// its reset value and the size/alignment check applied at accept time.
package sram_req_bridge_pkg;
  import types_amba_pkg::*;

  // Word address kept at full bus width; the top truncates to the window size.
  localparam int unsigned WADDR_BITS = CFG_SYSBUS_ADDR_BITS - 3;

  typedef enum logic {
    STATE_INIT = 1'b0,
    STATE_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic                             valid;
    logic                             write;
    logic                             err;
    logic [WADDR_BITS-1:0]            addr;
    logic [CFG_SYSBUS_DATA_BITS-1:0]  wdata;
    logic [CFG_SYSBUS_DATA_BYTES-1:0] wstrb;
  } stage_t;

  localparam stage_t sram_req_bridge_r_reset = '0;

  // Flags sizes other than 1/2/4/8 bytes and accesses not naturally aligned.
  function automatic logic size_check(input logic [CFG_SYSBUS_ADDR_BITS-1:0] addr,
                                      input logic [7:0]                      size);
    logic bad_size;
    logic misaligned;
    bad_size   = !(size inside {8'd1, 8'd2, 8'd4, 8'd8});
    misaligned = |(addr[7:0] & (size - 8'd1));
    return bad_size | misaligned;
  endfunction

endpackage : sram_req_bridge_pkg

// File: rtl/types_amba_pkg.sv
// System-bus geometry shared by the bus adapters and their endpoints.
package types_amba_pkg;

  localparam int unsigned CFG_SYSBUS_ADDR_BITS  = 48;
  localparam int unsigned CFG_SYSBUS_DATA_BITS  = 64;
  localparam int unsigned CFG_SYSBUS_DATA_BYTES = CFG_SYSBUS_DATA_BITS / 8;

endpackage : types_amba_pkg

// File: rtl/sram_req_bridge.sv
// Request/response endpoint driving a 1-cycle-latency single-port SRAM.
// Define SRAM_REQ_BRIDGE_INIT_EN to zero-fill the SRAM after every reset.
module sram_req_bridge
  import types_amba_pkg::*;
  import sram_req_bridge_pkg::*;
#(
  parameter int unsigned abits = 16
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_req_valid,
  input  logic [CFG_SYSBUS_ADDR_BITS-1:0]  i_req_addr,
  input  logic [7:0]                       i_req_size,
  input  logic                             i_req_write,
  input  logic [CFG_SYSBUS_DATA_BITS-1:0]  i_req_wdata,
  input  logic [CFG_SYSBUS_DATA_BYTES-1:0] i_req_wstrb,
  input  logic                             i_req_last,
  output logic                             o_req_ready,
  output logic                             o_resp_valid,
  output logic [CFG_SYSBUS_DATA_BITS-1:0]  o_resp_rdata,
  output logic                             o_resp_err,
  output logic                             o_mem_cs,
  output logic                             o_mem_we,
  output logic [abits-4:0]                 o_mem_addr,
  output logic [CFG_SYSBUS_DATA_BITS-1:0]  o_mem_wdata,
  output logic [CFG_SYSBUS_DATA_BYTES-1:0] o_mem_wstrb,
  input  logic [CFG_SYSBUS_DATA_BITS-1:0]  i_mem_rdata
);

  localparam int unsigned MEM_AW = abits - 3;

`ifdef SRAM_REQ_BRIDGE_INIT_EN
  localparam state_e STATE_RESET = STATE_INIT;
`else
  localparam state_e STATE_RESET = STATE_RUN;
`endif

  state_e state_q;
  stage_t cmd_q, cmd_d;
  logic   resp_valid_q;
  logic   resp_err_q;
  logic   resp_rd_q;

  logic   accept_c;
  logic   out_of_range_c;
  logic   req_err_c;
  logic   cmd_cs_c;

  assign o_req_ready    = (state_q == STATE_RUN) & ~i_rst;
  assign accept_c       = i_req_valid & o_req_ready;
  assign out_of_range_c = (i_req_addr >> abits) != '0;
  assign req_err_c      = out_of_range_c | size_check(i_req_addr, i_req_size);

  // Command stage payload captured on accept.
  always_comb begin
    cmd_d = sram_req_bridge_r_reset;
    if (accept_c) begin
      cmd_d.valid = 1'b1;
      cmd_d.write = i_req_write;
      cmd_d.err   = req_err_c;
      cmd_d.addr  = WADDR_BITS'(i_req_addr >> 3);
      cmd_d.wdata = i_req_wdata;
      cmd_d.wstrb = i_req_wstrb;
    end
  end

`ifdef SRAM_REQ_BRIDGE_INIT_EN
  logic [MEM_AW-1:0] sweep_cnt_q;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= STATE_RESET;
      cmd_q        <= sram_req_bridge_r_reset;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rd_q    <= 1'b0;
`ifdef SRAM_REQ_BRIDGE_INIT_EN
      sweep_cnt_q  <= '0;
`endif
    end else begin
      cmd_q        <= cmd_d;
      resp_valid_q <= cmd_q.valid;
      resp_err_q   <= cmd_q.valid & cmd_q.err;
      resp_rd_q    <= cmd_q.valid & ~cmd_q.err & ~cmd_q.write;
      case (state_q)
        STATE_INIT: begin
`ifdef SRAM_REQ_BRIDGE_INIT_EN
          sweep_cnt_q <= sweep_cnt_q + MEM_AW'(1);
          if (&sweep_cnt_q) begin
            state_q <= STATE_RUN;
          end
`else
          state_q <= STATE_RUN;
`endif
        end
        STATE_RUN: state_q <= STATE_RUN;
        default:   state_q <= STATE_RUN;
      endcase
    end
  end

  assign cmd_cs_c = cmd_q.valid & ~cmd_q.err;

  // The sweep owns the SRAM port while in STATE_INIT; no requests are in flight then.
`ifdef SRAM_REQ_BRIDGE_INIT_EN
  logic init_c;
  assign init_c      = (state_q == STATE_INIT) & ~i_rst;
  assign o_mem_cs    = init_c | cmd_cs_c;
  assign o_mem_we    = init_c | (cmd_cs_c & cmd_q.write);
  assign o_mem_addr  = init_c ? sweep_cnt_q : MEM_AW'(cmd_q.addr);
  assign o_mem_wdata = init_c ? '0 : cmd_q.wdata;
  assign o_mem_wstrb = init_c ? '1 : cmd_q.wstrb;
`else
  assign o_mem_cs    = cmd_cs_c;
  assign o_mem_we    = cmd_cs_c & cmd_q.write;
  assign o_mem_addr  = MEM_AW'(cmd_q.addr);
  assign o_mem_wdata = cmd_q.wdata;
  assign o_mem_wstrb = cmd_q.wstrb;
`endif

  assign o_resp_valid = resp_valid_q;
  assign o_resp_err   = resp_err_q;
  assign o_resp_rdata = resp_rd_q ? i_mem_rdata : '0;

  // i_req_last is informational; upper word-address bits are always zero after the range check.
  logic unused_c;
  assign unused_c = ^{i_req_last, cmd_q.addr};

endmodule : sram_req_bridge

// File: tb/tb_sram_req_bridge.sv
// Directed bench for sram_req_bridge with a behavioural 1-cycle SRAM model.
module tb_sram_req_bridge;
  import types_amba_pkg::*;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_req_valid;
  logic [47:0] i_req_addr;
  logic [7:0]  i_req_size;
  logic        i_req_write;
  logic [63:0] i_req_wdata;
  logic [7:0]  i_req_wstrb;
  logic        i_req_last;
  logic        o_req_ready;
  logic        o_resp_valid;
  logic [63:0] o_resp_rdata;
  logic        o_resp_err;
  logic        o_mem_cs;
  logic        o_mem_we;
  logic [12:0] o_mem_addr;
  logic [63:0] o_mem_wdata;
  logic [7:0]  o_mem_wstrb;
  logic [63:0] i_mem_rdata;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  sram_req_bridge #(.abits(16)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_size(i_req_size),
    .i_req_write(i_req_write), .i_req_wdata(i_req_wdata), .i_req_wstrb(i_req_wstrb),
    .i_req_last(i_req_last), .o_req_ready(o_req_ready),
    .o_resp_valid(o_resp_valid), .o_resp_rdata(o_resp_rdata), .o_resp_err(o_resp_err),
    .o_mem_cs(o_mem_cs), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb), .i_mem_rdata(i_mem_rdata)
  );

  // SRAM macro model, pre-filled with a nonzero pattern.
  logic [63:0] mem [0:8191];
  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
    i_mem_rdata = '0;
  end
  always @(posedge clk) begin
    if (o_mem_cs) begin
      if (o_mem_we) begin
        for (int b = 0; b < 8; b++)
          if (o_mem_wstrb[b]) mem[o_mem_addr][b*8 +: 8] <= o_mem_wdata[b*8 +: 8];
      end else begin
        i_mem_rdata <= mem[o_mem_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic put(input logic wr, input logic [47:0] a, input logic [7:0] sz,
                     input logic [63:0] d, input logic [7:0] s);
    i_req_valid = 1'b1;
    i_req_write = wr;
    i_req_addr  = a;
    i_req_size  = sz;
    i_req_wdata = d;
    i_req_wstrb = s;
    i_req_last  = 1'b1;
  endtask

  task automatic idle();
    i_req_valid = 1'b0;
    i_req_write = 1'b0;
    i_req_addr  = '0;
    i_req_size  = 8'd8;
    i_req_wdata = '0;
    i_req_wstrb = '0;
    i_req_last  = 1'b0;
  endtask

  // One request that must be rejected without touching the SRAM.
  task automatic err_read(input string tag, input logic [47:0] a, input logic [7:0] sz);
    @(negedge clk);
    put(1'b0, a, sz, 64'd0, 8'h00);
    chk({tag, "_ready"}, 64'(o_req_ready), 64'd1);
    @(negedge clk);
    idle();
    chk({tag, "_cs"}, 64'(o_mem_cs), 64'd0);
    @(negedge clk);
    chk({tag, "_rvalid"}, 64'(o_resp_valid), 64'd1);
    chk({tag, "_err"}, 64'(o_resp_err), 64'd1);
    chk({tag, "_rdata"}, o_resp_rdata, 64'd0);
  endtask

  int          bad;
  int          rcnt;
  logic [63:0] exp_rd;

  initial begin
    i_rst = 1'b1;
    idle();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 64'(o_req_ready), 64'd0);
    chk("rst_cs", 64'(o_mem_cs), 64'd0);
    chk("rst_we", 64'(o_mem_we), 64'd0);
    chk("rst_rvalid", 64'(o_resp_valid), 64'd0);
    chk("rst_err", 64'(o_resp_err), 64'd0);
    @(negedge clk);
    i_rst = 1'b0;

`ifdef SRAM_REQ_BRIDGE_INIT_EN
    bad = 0;
    for (int i = 0; i < 8192; i++) begin
      #1;
      if (!(o_mem_cs && o_mem_we && o_mem_addr == 13'(i) && o_mem_wstrb == 8'hFF &&
            o_mem_wdata == 64'd0 && !o_req_ready)) bad++;
      @(negedge clk);
    end
    #1;
    chk("sweep_bad_cycles", 64'(bad), 64'd0);
    chk("sweep_ready", 64'(o_req_ready), 64'd1);
    chk("sweep_cs_off", 64'(o_mem_cs), 64'd0);
    exp_rd = 64'd0;
`else
    #1;
    chk("run_ready", 64'(o_req_ready), 64'd1);
    chk("run_cs_off", 64'(o_mem_cs), 64'd0);
    exp_rd = 64'hA5A5_0000_0000_0020;
`endif

    // Read of word 0x20
    @(negedge clk);
    put(1'b0, 48'h100, 8'd8, 64'd0, 8'h00);
    @(negedge clk);
    idle();
    chk("rd100_cs", 64'(o_mem_cs), 64'd1);
    chk("rd100_we", 64'(o_mem_we), 64'd0);
    chk("rd100_addr", 64'(o_mem_addr), 64'h20);
    @(negedge clk);
    chk("rd100_rvalid", 64'(o_resp_valid), 64'd1);
    chk("rd100_err", 64'(o_resp_err), 64'd0);
    chk("rd100_rdata", o_resp_rdata, exp_rd);

    // Full-word write then immediate read of the same word
    @(negedge clk);
    put(1'b1, 48'h8, 8'd8, 64'h0011223344556677, 8'hFF);
    @(negedge clk);
    put(1'b0, 48'h8, 8'd8, 64'd0, 8'h00);
    chk("wr8_cs", 64'(o_mem_cs), 64'd1);
    chk("wr8_we", 64'(o_mem_we), 64'd1);
    chk("wr8_addr", 64'(o_mem_addr), 64'd1);
    chk("wr8_wdata", o_mem_wdata, 64'h0011223344556677);
    @(negedge clk);
    idle();
    chk("wr8_rvalid", 64'(o_resp_valid), 64'd1);
    chk("wr8_err", 64'(o_resp_err), 64'd0);
    chk("wr8_rdata", o_resp_rdata, 64'd0);
    chk("rd8_we", 64'(o_mem_we), 64'd0);
    @(negedge clk);
    chk("rd8_rvalid", 64'(o_resp_valid), 64'd1);
    chk("rd8_rdata", o_resp_rdata, 64'h0011223344556677);
    @(negedge clk);
    chk("pulse_end", 64'(o_resp_valid), 64'd0);

    // Halfword write into lanes 2..3
    put(1'b1, 48'hA, 8'd2, 64'h0000_0000_BEEF_0000, 8'h0C);
    @(negedge clk);
    put(1'b0, 48'h8, 8'd8, 64'd0, 8'h00);
    chk("wr2_wstrb", 64'(o_mem_wstrb), 64'h0C);
    @(negedge clk);
    idle();
    chk("wr2_err", 64'(o_resp_err), 64'd0);
    @(negedge clk);
    chk("rd8b_rdata", o_resp_rdata, 64'h00112233_BEEF_6677);

    err_read("oor", 48'h10000, 8'd8);
    err_read("misal", 48'h6, 8'd4);
    err_read("size3", 48'h0, 8'd3);
    repeat (2) @(negedge clk);

    // Back-to-back reads interrupted by reset after the fifth accept
    rcnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (o_resp_valid) rcnt++;
      put(1'b0, 48'(i * 8), 8'd8, 64'd0, 8'h00);
    end
    @(posedge clk);
    #2;
    i_rst = 1'b1;
    idle();
    #1;
    chk("b2b_resp_before_rst", 64'(rcnt), 64'd3);
    chk("midrst_rvalid", 64'(o_resp_valid), 64'd0);
    chk("midrst_cs", 64'(o_mem_cs), 64'd0);
    chk("midrst_ready", 64'(o_req_ready), 64'd0);
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    #1;
`ifdef SRAM_REQ_BRIDGE_INIT_EN
    chk("resweep_cs", 64'(o_mem_cs), 64'd1);
    chk("resweep_addr", 64'(o_mem_addr), 64'd0);
    chk("resweep_ready", 64'(o_req_ready), 64'd0);
`else
    chk("rerun_ready", 64'(o_req_ready), 64'd1);
    chk("rerun_cs", 64'(o_mem_cs), 64'd0);
`endif
    rcnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_resp_valid) rcnt++;
    end
    chk("no_resp_after_rst", 64'(rcnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_sram_req_bridge
